// File: rtl/mul_issue_ctrl_if.sv
// Handshake and multiplier-side bundle for mul_issue_ctrl.
// The slave modport is the controller's view; the master modport is the ALU/multiplier side.
interface mul_issue_ctrl_if #(
   parameter int WIDTH = 8
);
   logic                 req_valid;
   logic                 req_ready;
   logic [WIDTH-1:0]     op_a;
   logic [WIDTH-1:0]     op_b;
   logic                 op_signed;
   logic                 mul_start;
   logic [WIDTH-1:0]     mul_a;
   logic [WIDTH-1:0]     mul_b;
   logic                 mul_done;
   logic [2*WIDTH-1:0]   mul_product;
   logic                 res_valid;
   logic                 res_ready;
   logic [2*WIDTH-1:0]   result;
   logic                 res_err;

   modport slave (
      input  req_valid, op_a, op_b, op_signed, mul_done, mul_product, res_ready,
      output req_ready, mul_start, mul_a, mul_b, res_valid, result, res_err
   );

   modport master (
      output req_valid, op_a, op_b, op_signed, mul_done, mul_product, res_ready,
      input  req_ready, mul_start, mul_a, mul_b, res_valid, result, res_err
   );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue/return controller in front of the shift-add multiplier, with watchdog abort.
// Define MUL_SIGNED_EN to honour op_signed (magnitude conversion and product negation).
module mul_issue_ctrl #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 15
) (
   input  logic            i_clk,
   input  logic            i_rst,
   mul_issue_ctrl_if.slave bus
);
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_FIX   = 3'd3;
   localparam logic [2:0] S_OUT   = 3'd4;

   logic [2:0]           r_state;
   logic [WD_W-1:0]      r_wdog;
   logic                 r_sign;
   logic [2*WIDTH-1:0]   r_prod;
   logic                 r_req_ready;
   logic                 r_mul_start;
   logic [WIDTH-1:0]     r_mul_a;
   logic [WIDTH-1:0]     r_mul_b;
   logic                 r_res_valid;
   logic [2*WIDTH-1:0]   r_result;
   logic                 r_res_err;

   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic                 w_sign;
   logic [2*WIDTH-1:0]   w_fix;

`ifdef MUL_SIGNED_EN
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
      return (s && v[WIDTH-1]) ? ((~v) + WIDTH'(1)) : v;
   endfunction

   // The most-negative operand negates to itself, which is its correct unsigned magnitude.
   assign w_mag_a = mag(bus.op_a, bus.op_signed);
   assign w_mag_b = mag(bus.op_b, bus.op_signed);
   assign w_sign  = bus.op_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
   assign w_fix   = r_sign ? ((~r_prod) + (2*WIDTH)'(1)) : r_prod;
`else
   logic w_unused_sign;
   assign w_mag_a       = bus.op_a;
   assign w_mag_b       = bus.op_b;
   assign w_sign        = 1'b0;
   assign w_fix         = r_prod;
   assign w_unused_sign = bus.op_signed ^ r_sign;
`endif

   assign bus.req_ready = r_req_ready;
   assign bus.mul_start = r_mul_start;
   assign bus.mul_a     = r_mul_a;
   assign bus.mul_b     = r_mul_b;
   assign bus.res_valid = r_res_valid;
   assign bus.result    = r_result;
   assign bus.res_err   = r_res_err;

   // Controller FSM; all outputs are registered and only change on state transitions.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_wdog      <= '0;
         r_sign      <= 1'b0;
         r_prod      <= '0;
         r_req_ready <= 1'b1;
         r_mul_start <= 1'b0;
         r_mul_a     <= '0;
         r_mul_b     <= '0;
         r_res_valid <= 1'b0;
         r_result    <= '0;
         r_res_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid && r_req_ready) begin
                  r_mul_a     <= w_mag_a;
                  r_mul_b     <= w_mag_b;
                  r_sign      <= w_sign;
                  r_req_ready <= 1'b0;
                  r_mul_start <= 1'b1;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_mul_start <= 1'b0;
               r_wdog      <= '0;
               r_state     <= S_WAIT;
            end
            S_WAIT: begin
               // A done arriving on the last watchdog cycle still takes the normal path.
               if (bus.mul_done) begin
                  r_prod  <= bus.mul_product;
                  r_state <= S_FIX;
               end else if (r_wdog == WD_LAST) begin
                  r_wdog      <= r_wdog + WD_W'(1);
                  r_result    <= '0;
                  r_res_err   <= 1'b1;
                  r_res_valid <= 1'b1;
                  r_state     <= S_OUT;
               end else begin
                  r_wdog <= r_wdog + WD_W'(1);
               end
            end
            S_FIX: begin
               r_result    <= w_fix;
               r_res_err   <= 1'b0;
               r_res_valid <= 1'b1;
               r_state     <= S_OUT;
            end
            S_OUT: begin
               if (bus.res_ready) begin
                  r_res_valid <= 1'b0;
                  r_res_err   <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
               r_mul_start <= 1'b0;
               r_res_valid <= 1'b0;
               r_res_err   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl; the bench itself plays the multiplier.
module tb_mul_issue_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_mis = 0;
   logic [16:0] exp_q[$];

   mul_issue_ctrl_if #(.WIDTH(8)) bus ();

   mul_issue_ctrl #(.WIDTH(8), .TIMEOUT(15)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] mag(input logic [7:0] v, input logic s);
      logic [7:0] z;
      z = 8'd0;
      return (s && v[7]) ? (z - v) : v;
   endfunction

   // done_cyc: WAIT cycle (1..15) in which mul_done pulses; 0 means never (watchdog).
   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input int done_cyc, input int bp);
      logic               se;
      logic [7:0]         ma;
      logic [7:0]         mb;
      logic signed [15:0] sa;
      logic signed [15:0] sb;
      logic [15:0]        sp;
      logic [16:0]        exp;
      logic [16:0]        got;
      int                 n;
      se = 1'b0;
`ifdef MUL_SIGNED_EN
      se = s;
`endif
      ma = mag(a, se);
      mb = mag(b, se);
      if (se) begin
         sa = $signed({{8{a[7]}}, a});
         sb = $signed({{8{b[7]}}, b});
         sp = sa * sb;
      end else begin
         sp = {8'd0, a} * {8'd0, b};
      end
      exp = (done_cyc >= 1 && done_cyc <= 15) ? {1'b0, sp} : {1'b1, 16'h0000};

      bus.op_a      = a;
      bus.op_b      = b;
      bus.op_signed = s;
      bus.req_valid = 1'b1;
      chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
      exp_q.push_back(exp);
      tick();
      bus.req_valid = 1'b0;
      bus.op_a      = 8'h55;
      bus.op_b      = 8'hAA;
      bus.op_signed = ~s;
      chk("mul_start_issue", {31'd0, bus.mul_start}, 32'd1);
      chk("mul_a", {24'd0, bus.mul_a}, {24'd0, ma});
      chk("mul_b", {24'd0, bus.mul_b}, {24'd0, mb});
      chk("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
      tick();
      chk("mul_start_pulse", {31'd0, bus.mul_start}, 32'd0);

      if (done_cyc >= 1 && done_cyc <= 15) begin
         for (int i = 1; i < done_cyc; i++) tick();
         bus.mul_done    = 1'b1;
         bus.mul_product = {8'd0, ma} * {8'd0, mb};
         tick();
         bus.mul_done = 1'b0;
         n = 0;
         while (!bus.res_valid && n < 40) begin tick(); n++; end
         chk("fix_latency", n, 32'd1);
      end else begin
         n = 0;
         while (!bus.res_valid && n < 40) begin tick(); n++; end
         chk("wdog_cycles", n, 32'd15);
      end

      got = {bus.res_err, bus.result};
      if (exp_q.size() == 0) begin
         chk("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
         chk("result", {15'd0, got}, {15'd0, exp_q.pop_front()});
      end

      for (int i = 0; i < bp; i++) begin
         bus.mul_done    = (i == 1);
         bus.mul_product = 16'hFFFF;
         tick();
         bus.mul_done = 1'b0;
         chk("hold_result", {15'd0, bus.res_err, bus.result}, {15'd0, exp});
         chk("hold_valid", {31'd0, bus.res_valid}, 32'd1);
         chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
      end
      chk("mul_a_stable", {24'd0, bus.mul_a}, {24'd0, ma});

      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk("valid_cleared", {31'd0, bus.res_valid}, 32'd0);
      chk("err_cleared", {31'd0, bus.res_err}, 32'd0);
      chk("ready_again", {31'd0, bus.req_ready}, 32'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
      chk({tag, "_mul_start"}, {31'd0, bus.mul_start}, 32'd0);
      chk({tag, "_mul_a"}, {24'd0, bus.mul_a}, 32'd0);
      chk({tag, "_mul_b"}, {24'd0, bus.mul_b}, 32'd0);
      chk({tag, "_res_valid"}, {31'd0, bus.res_valid}, 32'd0);
      chk({tag, "_result"}, {16'd0, bus.result}, 32'd0);
      chk({tag, "_res_err"}, {31'd0, bus.res_err}, 32'd0);
   endtask

   initial begin
      rst             = 1'b1;
      bus.req_valid   = 1'b0;
      bus.op_a        = 8'h00;
      bus.op_b        = 8'h00;
      bus.op_signed   = 1'b0;
      bus.mul_done    = 1'b0;
      bus.mul_product = 16'h0000;
      bus.res_ready   = 1'b0;
      tick();
      tick();
      chk_reset_vals("reset");
      rst = 1'b0;
      tick();

      run_txn(8'h0C, 8'h0A, 1'b0, 9, 3);
      run_txn(8'hFD, 8'h05, 1'b1, 4, 0);
      run_txn(8'h80, 8'hFF, 1'b1, 2, 0);
      run_txn(8'hFF, 8'hFF, 1'b0, 1, 0);
      run_txn(8'h12, 8'h34, 1'b0, 0, 2);
      run_txn(8'h07, 8'h09, 1'b0, 15, 5);
      run_txn(8'h80, 8'h80, 1'b1, 3, 0);

      // Reset in the middle of WAIT, then a stale done while idle.
      bus.op_a      = 8'h11;
      bus.op_b      = 8'h22;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      tick();
      rst = 1'b0;
      bus.mul_done    = 1'b1;
      bus.mul_product = 16'h1234;
      tick();
      bus.mul_done = 1'b0;
      tick();
      chk("late_done_valid", {31'd0, bus.res_valid}, 32'd0);
      chk("late_done_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("late_done_result", {16'd0, bus.result}, 32'd0);

      run_txn(8'h21, 8'h03, 1'b0, 5, 1);
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
